fun: RTL and testbench

- Sequential arithmetic block that computes result = a_i × floor(∛b_i) for unsigned 8-bit operands.
- Uses an iterative digit-by-digit integer cube root followed by a multiply; multiplications are done on one shared sequential shift-add multiplier.
- Single start/busy handshake.
- Standalone compute unit driven by a controller that pulses start and polls busy.

---
 rtl/fun.sv | 120 ++++++++++++
 tb/tb_fun.sv | 118 +++++++++++
 2 files changed

// File: rtl/fun.sv
// Sequential unit computing result = a_i * floor(cbrt(b_i)) for 8-bit unsigned operands.
// A digit-by-digit cube root and the final product share one shift-add multiplier.
module fun (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  input  logic        start,
  output logic [10:0] result,
  output logic        busy
);

  typedef enum logic [2:0] {
    StIdle, StRootSetup, StRootMul, StRootCmp, StMulSetup, StMulRun, StDone
  } state_e;

  state_e      state_q;
  logic [7:0]  a_q;
  logic [7:0]  x_q;
  logic [2:0]  y_q;
  logic [1:0]  it_q;
  logic [15:0] acc_q;
  logic [15:0] mc_q;
  logic [7:0]  mp_q;
  logic [2:0]  cnt_q;

  logic [15:0] acc_step;
  logic [2:0]  y2;
  logic [13:0] tri_p;
  logic [3:0]  shamt;
  logic [13:0] t;
  logic        ge;

  always_comb begin
    acc_step = mp_q[0] ? acc_q + mc_q : acc_q;
    y2       = {y_q[1:0], 1'b0};
    // 3*y*(y+1) + 1 with the product taken from the multiplier accumulator
    tri_p    = acc_q[13:0] + {acc_q[12:0], 1'b0} + 14'd1;
    case (it_q)
      2'd0:    shamt = 4'd6;
      2'd1:    shamt = 4'd3;
      default: shamt = 4'd0;
    endcase
    t  = tri_p << shamt;
    ge = ({6'd0, x_q} >= t);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      it_q    <= '0;
      acc_q   <= '0;
      mc_q    <= '0;
      mp_q    <= '0;
      cnt_q   <= '0;
      result  <= '0;
      busy    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= a_i;
            x_q     <= b_i;
            y_q     <= '0;
            it_q    <= '0;
            busy    <= 1'b1;
            state_q <= StRootSetup;
          end
        end
        StRootSetup: begin
          y_q     <= y2;
          acc_q   <= '0;
          mc_q    <= {13'd0, y2};
          mp_q    <= {5'd0, y2} + 8'd1;
          cnt_q   <= '0;
          state_q <= StRootMul;
        end
        StRootMul: begin
          acc_q <= acc_step;
          mc_q  <= {mc_q[14:0], 1'b0};
          mp_q  <= {1'b0, mp_q[7:1]};
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_q <= StRootCmp;
        end
        StRootCmp: begin
          if (ge) begin
            x_q <= x_q - t[7:0];
            y_q <= y_q + 3'd1;
          end
          it_q    <= it_q + 2'd1;
          state_q <= (it_q == 2'd2) ? StMulSetup : StRootSetup;
        end
        StMulSetup: begin
          acc_q   <= '0;
          mc_q    <= {8'd0, a_q};
          mp_q    <= {5'd0, y_q};
          cnt_q   <= '0;
          state_q <= StMulRun;
        end
        StMulRun: begin
          acc_q <= acc_step;
          mc_q  <= {mc_q[14:0], 1'b0};
          mp_q  <= {1'b0, mp_q[7:1]};
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_q <= StDone;
        end
        StDone: begin
          result  <= acc_q[10:0];
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fun.sv
// Directed bench for fun: known products, boundaries, restart/reset during busy, cube-root sweep.
module tb_fun;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a_i;
  logic [7:0]  b_i;
  logic        start;
  logic [10:0] result;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int ref_lat = -1;

  fun dut (
    .clk    (clk),
    .rst    (rst),
    .a_i    (a_i),
    .b_i    (b_i),
    .start  (start),
    .result (result),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    a_i   = a;
    b_i   = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_i   = 8'($urandom);
    b_i   = 8'($urandom);
  endtask

  // lat0 = number of negedges already elapsed since the accept edge
  task automatic finish_op(input int exp, input string tag, input int lat0);
    int lat;
    lat = lat0;
    check({tag, " busy_high"}, int'(busy), 1);
    while (busy === 1'b1 && lat < 70) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " busy_fell"}, int'(busy), 0);
    check({tag, " lat_in_range"}, int'(lat >= 2 && lat <= 64), 1);
    if (ref_lat < 0) ref_lat = lat;
    else check({tag, " lat_const"}, lat, ref_lat);
    check({tag, " result"}, int'(result), exp);
  endtask

  task automatic op(input logic [7:0] a, input logic [7:0] b, input int exp, input string tag);
    start_op(a, b);
    finish_op(exp, tag, 1);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a_i   = '0;
    b_i   = '0;
    repeat (3) @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset result", int'(result), 0);
    rst = 1'b0;

    op(8'd5,   8'd27,  15,   "5x27");
    op(8'd3,   8'd64,  12,   "3x64");
    op(8'd9,   8'd125, 45,   "9x125");
    op(8'd255, 8'd255, 1530, "255x255");
    op(8'd200, 8'd0,   0,    "200x0");
    op(8'd0,   8'd125, 0,    "0x125");
    op(8'd7,   8'd7,   7,    "7x7");
    op(8'd10,  8'd8,   20,   "10x8");

    // start pulse with new operands while busy must be ignored
    start_op(8'd5, 8'd27);
    @(negedge clk);
    a_i   = 8'd9;
    b_i   = 8'd125;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_op(15, "restart_ignored", 3);

    // reset mid-operation clears busy and result
    start_op(8'd9, 8'd125);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset busy", int'(busy), 0);
    check("midreset result", int'(result), 0);
    rst = 1'b0;
    op(8'd3, 8'd64, 12, "after_reset 3x64");

    for (int b = 0; b < 256; b++) begin
      int r;
      r = 0;
      while ((r + 1) * (r + 1) * (r + 1) <= b) r++;
      op(8'd1, 8'(b), r, $sformatf("cbrt b=%0d", b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
